pa_fpu_frbus: RTL and testbench

PA_FPU_FRBUS -- requirements
Module: pa_fpu_frbus

---
 rtl/pa_fpu_pkg.sv | 9 +
 rtl/pa_fpu_frbus_fifo.sv | 37 +++
 rtl/pa_fpu_frbus.sv | 91 +++++++++
 tb/tb_pa_fpu_frbus.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pa_fpu_pkg.sv
// Shared FPU widths: result data, exception-flag and FP register-index fields.
package pa_fpu_pkg;
    localparam int FPU_FLEN = 32;
    localparam int FFLAG_W  = 5;
    localparam int REG_W    = 5;

    typedef logic [FFLAG_W-1:0] fflags_t;
    typedef logic [REG_W-1:0]   reg_idx_t;
endpackage

// File: rtl/pa_fpu_frbus_fifo.sv
// Two-slot writeback store: up to two writes per cycle (slot0 at wr_ptr, slot1 behind it), one read.
// Read data is combinational from rd_ptr; storage itself is never reset, only the pointers.
module pa_fpu_frbus_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 42
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr0_en,
    input  logic [W-1:0] wr0_dat,
    input  logic         wr1_en,
    input  logic [W-1:0] wr1_dat,
    input  logic         rd_en,
    output logic [W-1:0] rd_dat
);
    logic [W-1:0] mem [DEPTH];
    logic         wr_ptr;
    logic         rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            // Pointers are 1 bit wide, so adding 0/1/2 modulo 2 is an XOR with the parity.
            wr_ptr <= wr_ptr ^ (wr0_en ^ wr1_en);
            rd_ptr <= rd_ptr ^ rd_en;
        end
    end

    always_ff @(posedge clk) begin
        if (wr0_en) mem[wr_ptr] <= wr0_dat;
        if (wr1_en) mem[wr_ptr + 1'b1] <= wr1_dat;
    end

    assign rd_dat = mem[rd_ptr];
endmodule

// File: rtl/pa_fpu_frbus.sv
// FP result bus: merges EX2 and FDSU results into a 2-entry buffer feeding the FP register-file write port.
// One cycle push-to-request; FDSU is held off and EX1 stalled when the buffer would overflow.
module pa_fpu_frbus
    import pa_fpu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int FLEN  = FPU_FLEN
) (
    input  logic               forever_cpuclk,
    input  logic               cpurst,
    input  logic               ex2_inst_wb,
    input  logic [FLEN-1:0]    dp_frbus_ex2_data,
    input  logic [FFLAG_W-1:0] dp_frbus_ex2_fflags,
    input  logic [REG_W-1:0]   ctrl_frbus_ex2_dst_reg,
    input  logic               fdsu_frbus_wb_vld,
    input  logic [FLEN-1:0]    fdsu_frbus_data,
    input  logic [FFLAG_W-1:0] fdsu_frbus_fflags,
    input  logic [REG_W-1:0]   fdsu_frbus_dst_reg,
    output logic               frbus_fdsu_wb_grant,
    output logic               frbus_ctrl_ex1_stall,
    output logic               frbus_rf_wb_vld,
    output logic [FLEN-1:0]    frbus_rf_wb_data,
    output logic [REG_W-1:0]   frbus_rf_wb_reg,
    input  logic               rf_frbus_wb_ready,
    output logic               frbus_cp0_fflags_vld,
    output logic [FFLAG_W-1:0] frbus_cp0_fflags
);
    localparam int EW = FLEN + FFLAG_W + REG_W;

    logic [1:0]         count_q;
    logic [2:0]         count_d;
    logic [2:0]         occ_after_ex2;
    logic [1:0]         pushes;
    logic               ex2_push;
    logic               pop;
    logic [EW-1:0]      ex2_entry;
    logic [EW-1:0]      fdsu_entry;
    logic [EW-1:0]      rd_entry;
    logic [FFLAG_W-1:0] rd_fflags;

    assign ex2_entry  = {dp_frbus_ex2_data, dp_frbus_ex2_fflags, ctrl_frbus_ex2_dst_reg};
    assign fdsu_entry = {fdsu_frbus_data, fdsu_frbus_fflags, fdsu_frbus_dst_reg};

    assign frbus_rf_wb_vld = (count_q != 2'd0);
    assign pop             = frbus_rf_wb_vld && rf_frbus_wb_ready;
    assign ex2_push        = ex2_inst_wb && !cpurst;

    // FDSU only gets a slot left over after this cycle's EX2 push and pop.
    assign occ_after_ex2 = {1'b0, count_q} + {2'b0, ex2_push} - {2'b0, pop};
    assign frbus_fdsu_wb_grant = fdsu_frbus_wb_vld && !cpurst && (occ_after_ex2 < 3'd2);

    assign pushes  = {1'b0, ex2_push} + {1'b0, frbus_fdsu_wb_grant};
    assign count_d = {1'b0, count_q} + {1'b0, pushes} - {2'b0, pop};

    // A pending ungranted FDSU result will claim the last slot, so EX1 must hold too.
    assign frbus_ctrl_ex1_stall = !cpurst &&
        ((count_d == 3'd2) ||
         ((count_d == 3'd1) && fdsu_frbus_wb_vld && !frbus_fdsu_wb_grant));

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) count_q <= 2'd0;
        else        count_q <= count_d[1:0];
    end

    // FDSU goes into the earlier slot so it writes back ahead of a simultaneous EX2 result.
    pa_fpu_frbus_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk     (forever_cpuclk),
        .rst     (cpurst),
        .wr0_en  (frbus_fdsu_wb_grant || ex2_push),
        .wr0_dat (frbus_fdsu_wb_grant ? fdsu_entry : ex2_entry),
        .wr1_en  (frbus_fdsu_wb_grant && ex2_push),
        .wr1_dat (ex2_entry),
        .rd_en   (pop),
        .rd_dat  (rd_entry)
    );

    assign {frbus_rf_wb_data, rd_fflags, frbus_rf_wb_reg} = rd_entry;

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            frbus_cp0_fflags_vld <= 1'b0;
            frbus_cp0_fflags     <= '0;
        end else begin
            frbus_cp0_fflags_vld <= pop;
            frbus_cp0_fflags     <= pop ? rd_fflags : '0;
        end
    end
endmodule

// File: tb/tb_pa_fpu_frbus.sv
// Directed bench for pa_fpu_frbus: per-cycle vector table plus hand sequences for reset and streaming.
module tb_pa_fpu_frbus;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex2_inst_wb = 1'b0;
    logic [31:0] ex2_data = '0;
    logic [4:0]  ex2_fflags = '0;
    logic [4:0]  ex2_reg = '0;
    logic        fdsu_vld = 1'b0;
    logic [31:0] fdsu_data = '0;
    logic [4:0]  fdsu_fflags = '0;
    logic [4:0]  fdsu_reg = '0;
    logic        ready = 1'b1;
    logic        grant, stall, wb_vld, cp0_vld;
    logic [31:0] wb_data;
    logic [4:0]  wb_reg, cp0_fflags;

    int asserts = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pa_fpu_frbus dut (
        .forever_cpuclk         (clk),
        .cpurst                 (rst),
        .ex2_inst_wb            (ex2_inst_wb),
        .dp_frbus_ex2_data      (ex2_data),
        .dp_frbus_ex2_fflags    (ex2_fflags),
        .ctrl_frbus_ex2_dst_reg (ex2_reg),
        .fdsu_frbus_wb_vld      (fdsu_vld),
        .fdsu_frbus_data        (fdsu_data),
        .fdsu_frbus_fflags      (fdsu_fflags),
        .fdsu_frbus_dst_reg     (fdsu_reg),
        .frbus_fdsu_wb_grant    (grant),
        .frbus_ctrl_ex1_stall   (stall),
        .frbus_rf_wb_vld        (wb_vld),
        .frbus_rf_wb_data       (wb_data),
        .frbus_rf_wb_reg        (wb_reg),
        .rf_frbus_wb_ready      (ready),
        .frbus_cp0_fflags_vld   (cp0_vld),
        .frbus_cp0_fflags       (cp0_fflags)
    );

    typedef struct packed {
        logic        ex2;
        logic [31:0] edat;
        logic [4:0]  eflg;
        logic [4:0]  ereg;
        logic        fv;
        logic [31:0] fdat;
        logic [4:0]  fflg;
        logic [4:0]  freg;
        logic        rdy;
        logic        grant;
        logic        stall;
        logic        wvld;
        logic [31:0] wdat;
        logic [4:0]  wreg;
        logic        cvld;
        logic [4:0]  cflg;
    } vec_t;

    vec_t tbl [21];

    function automatic vec_t mk(input logic ex2, input logic [31:0] edat, input logic [4:0] eflg,
                                input logic [4:0] ereg, input logic fv, input logic [31:0] fdat,
                                input logic [4:0] fflg, input logic [4:0] freg, input logic rdy,
                                input logic g, input logic s, input logic w, input logic [31:0] wd,
                                input logic [4:0] wr, input logic cv, input logic [4:0] cf);
        vec_t v;
        v = '{ex2, edat, eflg, ereg, fv, fdat, fflg, freg, rdy, g, s, w, wd, wr, cv, cf};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // A push from EX2 into a full buffer with no pop is an upstream protocol violation.
    task automatic chk_overflow(input string name);
        asserts++;
        if (!rst && ex2_inst_wb && dut.count_q == 2'd2 && !(wb_vld && ready)) begin
            fails++;
            $display("FAIL %s overflow: got EX2 push into full buffer expected none", name);
        end
    endtask

    task automatic drive(input logic e, input logic [31:0] ed, input logic [4:0] ef, input logic [4:0] er,
                         input logic f, input logic [31:0] fd, input logic [4:0] ff, input logic [4:0] fr,
                         input logic r);
        ex2_inst_wb = e; ex2_data = ed; ex2_fflags = ef; ex2_reg = er;
        fdsu_vld = f; fdsu_data = fd; fdsu_fflags = ff; fdsu_reg = fr;
        ready = r;
    endtask

    initial begin
        logic [31:0] exp_d;
        logic [4:0]  exp_r;

        //            ex2 edat          eflg    ereg  fv fdat   fflg    freg  rdy  g  s  w  wdat          wreg  cv cflg
        tbl[0]  = mk(1, 32'h7FC00000, 5'h04, 5'd3,  0, 32'h0,  5'h00, 5'd0,  1,  0, 0, 0, 32'h0,        5'd0,  0, 5'h00);
        tbl[1]  = mk(0, 32'h0,        5'h00, 5'd0,  0, 32'h0,  5'h00, 5'd0,  1,  0, 0, 1, 32'h7FC00000, 5'd3,  0, 5'h00);
        tbl[2]  = mk(0, 32'h0,        5'h00, 5'd0,  0, 32'h0,  5'h00, 5'd0,  1,  0, 0, 0, 32'h0,        5'd0,  1, 5'h04);
        tbl[3]  = mk(1, 32'hA4,       5'h00, 5'd4,  1, 32'hF5, 5'h00, 5'd5,  1,  1, 1, 0, 32'h0,        5'd0,  0, 5'h00);
        tbl[4]  = mk(0, 32'h0,        5'h00, 5'd0,  0, 32'h0,  5'h00, 5'd0,  1,  0, 0, 1, 32'hF5,       5'd5,  0, 5'h00);
        tbl[5]  = mk(0, 32'h0,        5'h00, 5'd0,  0, 32'h0,  5'h00, 5'd0,  1,  0, 0, 1, 32'hA4,       5'd4,  1, 5'h00);
        tbl[6]  = mk(0, 32'h0,        5'h00, 5'd0,  0, 32'h0,  5'h00, 5'd0,  1,  0, 0, 0, 32'h0,        5'd0,  1, 5'h00);
        tbl[7]  = mk(1, 32'h11,       5'h01, 5'd7,  0, 32'h0,  5'h00, 5'd0,  1,  0, 0, 0, 32'h0,        5'd0,  0, 5'h00);
        tbl[8]  = mk(1, 32'h22,       5'h10, 5'd8,  0, 32'h0,  5'h00, 5'd0,  1,  0, 0, 1, 32'h11,       5'd7,  0, 5'h00);
        tbl[9]  = mk(0, 32'h0,        5'h00, 5'd0,  0, 32'h0,  5'h00, 5'd0,  1,  0, 0, 1, 32'h22,       5'd8,  1, 5'h01);
        tbl[10] = mk(0, 32'h0,        5'h00, 5'd0,  0, 32'h0,  5'h00, 5'd0,  1,  0, 0, 0, 32'h0,        5'd0,  1, 5'h10);
        tbl[11] = mk(0, 32'h0,        5'h00, 5'd0,  0, 32'h0,  5'h00, 5'd0,  1,  0, 0, 0, 32'h0,        5'd0,  0, 5'h00);
        tbl[12] = mk(0, 32'h0,        5'h00, 5'd0,  1, 32'h33, 5'h02, 5'd9,  0,  1, 0, 0, 32'h0,        5'd0,  0, 5'h00);
        tbl[13] = mk(0, 32'h0,        5'h00, 5'd0,  1, 32'h44, 5'h00, 5'd10, 0,  1, 1, 1, 32'h33,       5'd9,  0, 5'h00);
        tbl[14] = mk(0, 32'h0,        5'h00, 5'd0,  1, 32'h55, 5'h03, 5'd11, 0,  0, 1, 1, 32'h33,       5'd9,  0, 5'h00);
        tbl[15] = mk(0, 32'h0,        5'h00, 5'd0,  1, 32'h55, 5'h03, 5'd11, 0,  0, 1, 1, 32'h33,       5'd9,  0, 5'h00);
        tbl[16] = mk(0, 32'h0,        5'h00, 5'd0,  1, 32'h55, 5'h03, 5'd11, 1,  1, 1, 1, 32'h33,       5'd9,  0, 5'h00);
        tbl[17] = mk(0, 32'h0,        5'h00, 5'd0,  0, 32'h0,  5'h00, 5'd0,  1,  0, 0, 1, 32'h44,       5'd10, 1, 5'h02);
        tbl[18] = mk(0, 32'h0,        5'h00, 5'd0,  0, 32'h0,  5'h00, 5'd0,  1,  0, 0, 1, 32'h55,       5'd11, 1, 5'h00);
        tbl[19] = mk(0, 32'h0,        5'h00, 5'd0,  0, 32'h0,  5'h00, 5'd0,  1,  0, 0, 0, 32'h0,        5'd0,  1, 5'h03);
        tbl[20] = mk(0, 32'h0,        5'h00, 5'd0,  0, 32'h0,  5'h00, 5'd0,  1,  0, 0, 0, 32'h0,        5'd0,  0, 5'h00);

        // Reset state, with an FDSU request present that must not be granted.
        #1 rst = 1'b1;
        drive(0, 0, 0, 0, 1, 32'hDEAD, 0, 5'd1, 1);
        #12;
        chk("reset wb_vld", {31'b0, wb_vld}, 32'd0);
        chk("reset grant", {31'b0, grant}, 32'd0);
        chk("reset stall", {31'b0, stall}, 32'd0);
        chk("reset cp0_vld", {31'b0, cp0_vld}, 32'd0);
        chk("reset cp0_fflags", {27'b0, cp0_fflags}, 32'd0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        rst = 1'b0;

        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            drive(tbl[i].ex2, tbl[i].edat, tbl[i].eflg, tbl[i].ereg,
                  tbl[i].fv, tbl[i].fdat, tbl[i].fflg, tbl[i].freg, tbl[i].rdy);
            #1;
            chk($sformatf("row%0d grant", i), {31'b0, grant}, {31'b0, tbl[i].grant});
            chk($sformatf("row%0d stall", i), {31'b0, stall}, {31'b0, tbl[i].stall});
            chk($sformatf("row%0d wb_vld", i), {31'b0, wb_vld}, {31'b0, tbl[i].wvld});
            if (tbl[i].wvld) begin
                chk($sformatf("row%0d wb_data", i), wb_data, tbl[i].wdat);
                chk($sformatf("row%0d wb_reg", i), {27'b0, wb_reg}, {27'b0, tbl[i].wreg});
            end
            chk($sformatf("row%0d cp0_vld", i), {31'b0, cp0_vld}, {31'b0, tbl[i].cvld});
            chk($sformatf("row%0d cp0_fflags", i), {27'b0, cp0_fflags}, {27'b0, tbl[i].cflg});
            chk_overflow($sformatf("row%0d", i));
        end

        // Sustained EX2 stream with the write port always free: one write per cycle, never a stall.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive(i < 8, 32'h1000 + i, 5'h00, 5'(i), 0, 0, 0, 0, 1);
            #1;
            chk($sformatf("stream%0d stall", i), {31'b0, stall}, 32'd0);
            chk($sformatf("stream%0d wb_vld", i), {31'b0, wb_vld}, {31'b0, i != 0});
            if (i != 0) begin
                exp_d = 32'h1000 + i - 1;
                exp_r = 5'(i - 1);
                chk($sformatf("stream%0d wb_data", i), wb_data, exp_d);
                chk($sformatf("stream%0d wb_reg", i), {27'b0, wb_reg}, {27'b0, exp_r});
            end
            chk_overflow($sformatf("stream%0d", i));
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        #1 chk("stream drained wb_vld", {31'b0, wb_vld}, 32'd0);

        // Two entries buffered, then reset mid-cycle: buffer must empty without a clock edge.
        @(negedge clk);
        drive(1, 32'hAAAA, 5'h01, 5'd20, 1, 32'hBBBB, 5'h02, 5'd21, 0);
        #1 chk("prerst stall", {31'b0, stall}, 32'd1);
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 32'hCCCC, 5'h00, 5'd22, 0);
        #1;
        chk("prerst wb_vld", {31'b0, wb_vld}, 32'd1);
        chk("prerst wb_reg", {27'b0, wb_reg}, 32'd21);
        chk("prerst grant", {31'b0, grant}, 32'd0);
        #1 rst = 1'b1;
        #1;
        chk("async rst wb_vld", {31'b0, wb_vld}, 32'd0);
        chk("async rst count", {30'b0, dut.count_q}, 32'd0);
        chk("async rst grant", {31'b0, grant}, 32'd0);
        chk("async rst stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("postrst%0d wb_vld", i), {31'b0, wb_vld}, 32'd0);
            chk($sformatf("postrst%0d cp0_vld", i), {31'b0, cp0_vld}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
